// File: rtl/mux8_ser_pkg.sv
// Shared types and width helpers for the mux8 serializer.
package mux8_ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    // $clog2 clamped to 1 so a DIV of 1 still gets a legal counter width.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mux8_serializer_bit_prescaler.sv
// DIV-cycle divider: while enabled, emits a one-cycle tick every DIV cycles.
module bit_prescaler
    import mux8_ser_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = clog2_min1(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/mux8_serializer.sv
// Handshaked parallel-to-serial stage, LSB first, each bit held DIV cycles.
// Define MUX8_SER_PARITY_EN to append an even-parity bit-slot after the word.
module mux8_serializer
    import mux8_ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [$clog2(WIDTH)-1:0] sel,
    output logic                     out_bit,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int            SW       = clog2_min1(WIDTH);
    localparam logic [SW-1:0] LAST_SEL = SW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] word;
    logic [SW-1:0]    sel_n, sel_inc;
    logic             bit_n, load, tick;

    assign sel_inc = sel + 1'b1;

    // Every status output is a pure decode of the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SHIFT) || (state == PARITY);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    bit_prescaler #(.DIV(DIV)) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (out_valid),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        sel_n   = sel;
        bit_n   = out_bit;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n = SHIFT;
                    sel_n   = '0;
                    bit_n   = in_data[0];
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sel == LAST_SEL) begin
`ifdef MUX8_SER_PARITY_EN
                        state_n = PARITY;
                        bit_n   = ^word;
`else
                        state_n = DONE;
                        bit_n   = 1'b0;
`endif
                    end else begin
                        sel_n = sel_inc;
                        bit_n = word[sel_inc];
                    end
                end
            end
`ifdef MUX8_SER_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_n = DONE;
                    bit_n   = 1'b0;
                end
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sel     <= '0;
            out_bit <= 1'b0;
            word    <= '0;
        end else begin
            state   <= state_n;
            sel     <= sel_n;
            out_bit <= bit_n;
            if (load)
                word <= in_data;
        end
    end

endmodule

// File: tb/tb_mux8_serializer.sv
// Directed + randomized bench for mux8_serializer; DIV=1 and DIV=4 instances side by side.
module tb_mux8_serializer;

`ifdef MUX8_SER_PARITY_EN
    localparam int NSLOT = 9;
`else
    localparam int NSLOT = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data   [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [2:0] sel       [2];
    logic       out_bit   [2];
    logic       out_valid [2];
    logic       busy      [2];
    logic       done      [2];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mux8_serializer #(.WIDTH(8), .DIV(1)) u_d1 (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .sel(sel[0]), .out_bit(out_bit[0]),
        .out_valid(out_valid[0]), .busy(busy[0]), .done(done[0])
    );

    mux8_serializer #(.WIDTH(8), .DIV(4)) u_d4 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .sel(sel[1]), .out_bit(out_bit[1]),
        .out_valid(out_valid[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_in_ready"},  32'(in_ready[d]),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid[d]), 32'd0);
        check({tag, "_busy"},      32'(busy[d]),      32'd0);
        check({tag, "_done"},      32'(done[d]),      32'd0);
    endtask

    // Reference: slot s = c/DIV; slots 0..7 carry w[s], slot 8 (if any) carries ^w.
    task automatic run_frame(input int d, input logic [7:0] w, input bit hold);
        int   divv;
        int   slot;
        logic exp_bit;
        divv = (d == 0) ? 1 : 4;
        check("pre_in_ready", 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1;
        in_data[d]  = w;
        step();
        in_valid[d] = hold;
        for (int c = 0; c < NSLOT * divv; c++) begin
            slot    = c / divv;
            exp_bit = (slot < 8) ? w[slot] : ^w;
            check("shift_out_valid", 32'(out_valid[d]), 32'd1);
            check("shift_busy",      32'(busy[d]),      32'd1);
            check("shift_in_ready",  32'(in_ready[d]),  32'd0);
            check("shift_done",      32'(done[d]),      32'd0);
            check("shift_sel",       32'(sel[d]),       32'((slot < 8) ? slot : 7));
            check("shift_out_bit",   32'(out_bit[d]),   32'(exp_bit));
            in_data[d] = 8'($urandom);
            step();
        end
        check("end_done",      32'(done[d]),      32'd1);
        check("end_out_valid", 32'(out_valid[d]), 32'd0);
        check("end_busy",      32'(busy[d]),      32'd1);
        check("end_in_ready",  32'(in_ready[d]),  32'd0);
        check("end_sel",       32'(sel[d]),       32'd7);
        step();
        check("post_in_ready", 32'(in_ready[d]), 32'd1);
        check("post_done",     32'(done[d]),     32'd0);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = 8'($urandom);
        end
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            check_idle(d, "rst");
            check("rst_sel",     32'(sel[d]),     32'd0);
            check("rst_out_bit", 32'(out_bit[d]), 32'd0);
        end
        reset       = 1'b0;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        step();
        check_idle(0, "nocap0");
        check_idle(1, "nocap1");

        run_frame(0, 8'hA5, 1'b0);
        run_frame(1, 8'h81, 1'b0);

        // Back-to-back with in_valid held high throughout.
        run_frame(0, 8'hFF, 1'b1);
        run_frame(0, 8'h00, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_frame(0, 8'($urandom), 1'b0);
            run_frame(1, 8'($urandom), 1'b0);
        end

        // Abort a frame at sel=3.
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hF0;
        step();
        in_valid[0] = 1'b0;
        step();
        step();
        step();
        check("mid_sel", 32'(sel[0]), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle(0, "abort");
        check("abort_sel", 32'(sel[0]), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("abort_no_done", 32'(done[0]), 32'd0);
            step();
        end
        run_frame(0, 8'h3C, 1'b0);

        run_frame(0, 8'h07, 1'b0);
        run_frame(0, 8'h03, 1'b0);
        run_frame(1, 8'h07, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux8_serializer.md
Name: mux8_serializer

Overview:
- Parallel-to-serial stage that accepts a WIDTH-bit word over a valid/ready handshake and walks an internal select counter across it, emitting one bit per bit-slot.
- Sits downstream of the 4-bit free-running counter / MUX8 pair. Replaces the external counter-drives-mux arrangement with a self-sequenced, handshaked block that feeds the serial output pins.

Parameters:
- WIDTH, 8, number of mux inputs (bits per frame); power of two, 2..16
- DIV, 1, clock cycles each bit is held; 1..16

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_data  in  WIDTH  parallel word to serialize
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word
- sel  out  $clog2(WIDTH)  index of bit currently driven
- out_bit  out  1  serial data, registered
- out_valid  out  1  out_bit is a frame bit
- busy  out  1  frame in progress (SHIFT or DONE)
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: clk and reset are the only clock and reset. Reset is synchronous and active-high.
  - On a clk edge with reset=1: state=IDLE, in_ready=1, sel=0, out_bit=0, out_valid=0, busy=0, done=0, prescaler=0, word register=0.
  - Reset overrides everything, including mid-frame. No done pulse is issued for an aborted frame.
- FSM: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. If in_valid=1 at an edge, in_data is captured into the word register and the next state is SHIFT with sel=0 and prescaler=0. No transfer occurs when in_valid=0.
  - SHIFT: in_ready=0, out_valid=1, busy=1, out_bit=word[sel].
    - The prescaler counts 0..DIV-1. When it reaches DIV-1 it wraps to 0 and sel increments.
    - When sel=WIDTH-1 and the prescaler reaches DIV-1, the next state is DONE.
  - DONE: lasts exactly one cycle. done=1, out_valid=0, busy=1, in_ready=0, sel holds WIDTH-1. Next state is IDLE.
- Order is LSB first: sel runs 0..WIDTH-1.
- Latency: handshake at edge k gives the first bit valid in cycle k+1.
  - SHIFT occupies WIDTH*DIV cycles.
  - done is high in cycle k+1+WIDTH*DIV.
  - in_ready returns in the following cycle.
  - Minimum frame-to-frame spacing is WIDTH*DIV+2 cycles.
- in_data changes while not in IDLE are ignored. The word is latched only on the handshake.
- DIV=1 means no prescaler hold: sel advances every cycle.
- sel never exceeds WIDTH-1 and does not wrap inside a frame.
- All outputs are registered or decoded from state registers only. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro: MUX8_SER_PARITY_EN.
- Defined:
  - After bit WIDTH-1, one extra bit-slot of DIV cycles drives even parity (XOR of the word) on out_bit, with out_valid=1 and sel held at WIDTH-1.
  - The extra state is PARITY, between SHIFT and DONE.
  - Frame length becomes (WIDTH+1)*DIV and done moves one slot later.
- Undefined: no PARITY state and no parity logic. Timing is exactly as in Behaviour.

Decomposition:
- Package mux8_ser_pkg:
  - state enum: IDLE, SHIFT, PARITY, DONE; PARITY is present in the enum unconditionally.
  - localparam helpers for sel width and prescaler width ($clog2 of DIV, minimum 1).
- Sub-module bit_prescaler(clk, reset, clr, en, tick):
  - DIV-cycle divider producing a one-cycle tick.
  - Instantiated once and cleared on the handshake.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, done=0, sel=0. No capture occurs.
- Single frame, DIV=1, WIDTH=8, in_data=8'hA5 -> out_bit sequence 1,0,1,0,0,1,0,1 with sel 0..7 over 8 cycles. done in cycle 9 after the handshake; in_ready=1 in cycle 10.
- DIV=4, in_data=8'h81 -> each bit held 4 cycles, 32 SHIFT cycles. out_bit=1 in cycles 1-4 and 29-32, 0 otherwise.
- Back-to-back: in_valid held high with 8'hFF then 8'h00 -> second word is accepted only in the IDLE cycle after done. in_data changes mid-frame do not alter out_bit.
- Reset mid-frame: reset=1 at sel=3 -> next cycle IDLE, out_valid=0, sel=0, no done pulse. A new frame then runs normally.
- MUX8_SER_PARITY_EN defined, in_data=8'h07 -> 9 bit-slots, parity slot out_bit=1, done at cycle 10 (DIV=1). 8'h03 gives parity bit 0.
